// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, default frame
// geometry and a parity helper.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 12;
    localparam int DATA_BITS_DEF  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_e;

    // XOR-reduction of up to eight bits; 1 means an odd number of ones.
    function automatic logic parity_odd8(input logic [7:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line (idle-high reset)
// with a falling-edge flag derived from the synchronised level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_in,
    output logic rx_s,
    output logic fall_s
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchroniser chain plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
            prev_r <= 1'b1;
        end else begin
            meta_r <= rx_in;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign rx_s   = sync_r;
    assign fall_s = prev_r & ~sync_r;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: oversampled start detect, mid-bit sampling, 8N1 (or
// 8E1 when UART_RX_PARITY_EN is defined) frame assembly with error flags.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Rx_clk,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int TCW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_BITS);
    localparam logic [TCW-1:0] TICK_MID = TCW'(OVERSAMPLE / 2 - 1);
    localparam logic [TCW-1:0] TICK_END = TCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

    uart_state_e          state_r;
    uart_state_e          state_next_s;
    logic                 rx_s;
    logic                 fall_s;
    logic [TCW-1:0]       tick_cnt_r;
    logic [BCW-1:0]       bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 mid_tick_s;
    logic                 end_tick_s;
    logic                 cnt_clr_s;
    logic                 samp_data_s;
    logic                 samp_stop_s;
    logic [DATA_BITS-1:0] data_out_r;
    logic                 data_valid_r;
    logic                 frame_err_r;
    logic                 parity_err_r;
    logic                 busy_r;
`ifdef UART_RX_PARITY_EN
    logic                 samp_par_s;
    logic                 par_bit_r;
`endif

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .rx_in  (rx_in),
        .rx_s   (rx_s),
        .fall_s (fall_s)
    );

    assign mid_tick_s = Rx_clk & (tick_cnt_r == TICK_MID);
    assign end_tick_s = Rx_clk & (tick_cnt_r == TICK_END);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) state_next_s = ST_START;
                else        state_next_s = ST_IDLE;
            end
            ST_START: begin
                if (mid_tick_s) state_next_s = rx_s ? ST_IDLE : ST_DATA;
                else            state_next_s = ST_START;
            end
            ST_DATA: begin
                if (end_tick_s && (bit_cnt_r == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
                    state_next_s = ST_PARITY;
`else
                    state_next_s = ST_STOP;
`endif
                end else begin
                    state_next_s = ST_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (end_tick_s) state_next_s = ST_STOP;
                else            state_next_s = ST_PARITY;
            end
`endif
            ST_STOP: begin
                if (end_tick_s) state_next_s = rx_s ? ST_IDLE : ST_BREAK;
                else            state_next_s = ST_STOP;
            end
            ST_BREAK: begin
                if (rx_s) state_next_s = ST_IDLE;
                else      state_next_s = ST_BREAK;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM control outputs: counter clear and per-state sample strobes.
    always_comb begin
        cnt_clr_s   = 1'b0;
        samp_data_s = 1'b0;
        samp_stop_s = 1'b0;
`ifdef UART_RX_PARITY_EN
        samp_par_s  = 1'b0;
`endif
        case (state_r)
            ST_IDLE:  cnt_clr_s = 1'b1;
            ST_START: cnt_clr_s = mid_tick_s;
            ST_DATA: begin
                samp_data_s = end_tick_s;
                cnt_clr_s   = end_tick_s;
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                samp_par_s = end_tick_s;
                cnt_clr_s  = end_tick_s;
            end
`endif
            ST_STOP: begin
                samp_stop_s = end_tick_s;
                cnt_clr_s   = end_tick_s;
            end
            ST_BREAK: cnt_clr_s = 1'b1;
            default:  cnt_clr_s = 1'b1;
        endcase
    end

    // Oversample tick counter; only moves on Rx_clk cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_r <= '0;
        end else if (cnt_clr_s) begin
            tick_cnt_r <= '0;
        end else if (Rx_clk) begin
            tick_cnt_r <= tick_cnt_r + TCW'(1);
        end else begin
            tick_cnt_r <= tick_cnt_r;
        end
    end

    // Data bit counter and LSB-first shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_r <= '0;
            shift_r   <= '0;
        end else if (state_r != ST_DATA) begin
            bit_cnt_r <= '0;
            shift_r   <= shift_r;
        end else if (samp_data_s) begin
            bit_cnt_r <= bit_cnt_r + BCW'(1);
            shift_r   <= {rx_s, shift_r[DATA_BITS-1:1]};
        end else begin
            bit_cnt_r <= bit_cnt_r;
            shift_r   <= shift_r;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Captured parity bit of the current frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit_r <= 1'b0;
        end else if (samp_par_s) begin
            par_bit_r <= rx_s;
        end else begin
            par_bit_r <= par_bit_r;
        end
    end
`endif

    // Result registers: updated together on the stop-bit sample, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_r   <= '0;
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
            if (samp_stop_s) begin
                data_valid_r <= 1'b1;
                data_out_r   <= shift_r;
                frame_err_r  <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                parity_err_r <= parity_odd8(8'(shift_r)) ^ par_bit_r;
`else
                parity_err_r <= 1'b0;
`endif
            end else begin
                data_valid_r <= 1'b0;
                data_out_r   <= data_out_r;
                frame_err_r  <= frame_err_r;
                parity_err_r <= parity_err_r;
            end
        end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign frame_err  = frame_err_r;
    assign parity_err = parity_err_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: table of single frames plus hand-written
// glitch, break, back-to-back and mid-frame reset sequences.
module tb_uart_rx_frame;

    localparam int TICK_DIV = 4;
    localparam int BIT      = 12 * TICK_DIV;

    logic       clk;
    logic       rst;
    logic       Rx_clk;
    logic       rx_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_cnt = 0;
    int tdiv = 0;
    logic prev_dv = 1'b0;
    logic [9:0] strobe_q[$];

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;
    vec_t vecs[$];

    uart_rx_frame dut (
        .clk        (clk),
        .rst        (rst),
        .Rx_clk     (Rx_clk),
        .rx_in      (rx_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        Rx_clk = 1'b0;
        forever begin
            @(negedge clk);
            tdiv = (tdiv == TICK_DIV - 1) ? 0 : tdiv + 1;
            Rx_clk = (tdiv == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Strobe monitor: strobe follows a tick, never two in a row; logs each result.
    always @(posedge clk) begin
        #1;
        if (data_valid) begin
            strobe_cnt++;
            strobe_q.push_back({frame_err, parity_err, data_out});
            check("strobe_follows_tick", 32'(Rx_clk), 32'(1'b1));
            check("strobe_not_back_to_back", 32'(prev_dv), 32'(1'b0));
        end
        prev_dv = data_valid;
    end

    task automatic send_level(input logic v, input int clks);
        rx_in = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_head(input logic [7:0] d, input logic par);
        send_level(1'b0, BIT);
        for (int i = 0; i < 8; i++) send_level(d[i], BIT);
`ifdef UART_RX_PARITY_EN
        send_level(par, BIT);
`else
        if (par) rx_in = 1'b1;
`endif
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par);
        send_head(d, par);
        send_level(1'b1, BIT);
    endtask

    initial begin
        int c0;
        int q0;
        rst = 1'b1;
        rx_in = 1'b1;

        // par = bit that makes data+parity even
        vecs.push_back('{8'hA5, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h5A, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h01, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'hC3, 1'b0, 1'b0, 1'b0});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h07, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'hC3, 1'b0, 1'b0, 1'b0});
`endif

        repeat (5) @(negedge clk);
        check("reset_data_out", 32'(data_out), 32'(8'h00));
        check("reset_data_valid", 32'(data_valid), 32'(1'b0));
        check("reset_frame_err", 32'(frame_err), 32'(1'b0));
        check("reset_parity_err", 32'(parity_err), 32'(1'b0));
        check("reset_busy", 32'(busy), 32'(1'b0));
        rst = 1'b0;
        repeat (BIT) @(negedge clk);

        for (int v = 0; v < vecs.size(); v++) begin
            c0 = strobe_cnt;
            send_frame(vecs[v].data, vecs[v].par);
            repeat (BIT) @(negedge clk);
            check("vec_strobe_count", 32'(strobe_cnt - c0), 32'd1);
            check("vec_data_out", 32'(data_out), 32'(vecs[v].data));
            check("vec_frame_err", 32'(frame_err), 32'(vecs[v].exp_ferr));
            check("vec_parity_err", 32'(parity_err), 32'(vecs[v].exp_perr));
            check("vec_busy_idle", 32'(busy), 32'(1'b0));
        end

        // Short low glitch: start rejected at mid-bit, no strobe, data held.
        c0 = strobe_cnt;
        send_level(1'b0, 3 * TICK_DIV);
        check("glitch_busy_in_start", 32'(busy), 32'(1'b1));
        send_level(1'b1, 2 * BIT);
        check("glitch_no_strobe", 32'(strobe_cnt - c0), 32'd0);
        check("glitch_data_held", 32'(data_out), 32'(8'hC3));
        check("glitch_busy_idle", 32'(busy), 32'(1'b0));

        // Stop bit held low two bit-times: one strobe with frame_err, then BREAK.
        c0 = strobe_cnt;
        send_head(8'h3C, 1'b0);
        send_level(1'b0, 2 * BIT);
        check("break_one_strobe", 32'(strobe_cnt - c0), 32'd1);
        check("break_data_out", 32'(data_out), 32'(8'h3C));
        check("break_frame_err", 32'(frame_err), 32'(1'b1));
        check("break_busy_low_line", 32'(busy), 32'(1'b1));
        send_level(1'b1, BIT);
        check("break_busy_released", 32'(busy), 32'(1'b0));
        check("break_no_second_strobe", 32'(strobe_cnt - c0), 32'd1);

        // Back-to-back frames with zero idle.
        q0 = strobe_q.size();
        send_frame(8'h00, 1'b0);
        send_frame(8'hFF, 1'b0);
        send_frame(8'h81, 1'b0);
        repeat (BIT) @(negedge clk);
        check("b2b_strobe_count", 32'(strobe_q.size() - q0), 32'd3);
        if (strobe_q.size() >= q0 + 3) begin
            check("b2b_first", 32'(strobe_q[q0]), 32'(10'h000));
            check("b2b_second", 32'(strobe_q[q0 + 1]), 32'(10'h0FF));
            check("b2b_third", 32'(strobe_q[q0 + 2]), 32'(10'h081));
        end

        // Reset in the middle of the data bits of 0x55.
        c0 = strobe_cnt;
        send_level(1'b0, BIT);
        send_level(1'b1, BIT);
        send_level(1'b0, BIT);
        send_level(1'b1, BIT / 2);
        check("midrst_busy_before", 32'(busy), 32'(1'b1));
        rst = 1'b1;
        rx_in = 1'b1;
        @(negedge clk);
        check("midrst_data_out", 32'(data_out), 32'(8'h00));
        check("midrst_data_valid", 32'(data_valid), 32'(1'b0));
        check("midrst_frame_err", 32'(frame_err), 32'(1'b0));
        check("midrst_busy", 32'(busy), 32'(1'b0));
        rst = 1'b0;
        repeat (2 * BIT) @(negedge clk);
        check("midrst_no_strobe", 32'(strobe_cnt - c0), 32'd0);
        send_frame(8'h12, 1'b0);
        repeat (BIT) @(negedge clk);
        check("after_rst_strobe", 32'(strobe_cnt - c0), 32'd1);
        check("after_rst_data", 32'(data_out), 32'(8'h12));
        check("after_rst_frame_err", 32'(frame_err), 32'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
